// File: rtl/usb_pkg.sv
// Shared USB TX definitions: request codes, PID bytes, SYNC pattern and CRC16 constants.
package usb_pkg;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_DATA1 = 3'd2,
    TX_ACK   = 3'd3,
    TX_NAK   = 3'd4,
    TX_STALL = 3'd5
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA_REQ,
    ST_DATA_WAIT,
    ST_DATA_SEND,
    ST_CRC_LO,
    ST_CRC_HI
  } tx_state_t;

  localparam logic [7:0]  PID_DATA0 = 8'hC3;
  localparam logic [7:0]  PID_DATA1 = 8'h4B;
  localparam logic [7:0]  PID_ACK   = 8'hD2;
  localparam logic [7:0]  PID_NAK   = 8'h5A;
  localparam logic [7:0]  PID_STALL = 8'h1E;

  localparam logic [7:0]  SYNC_BYTE       = 8'h80;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  function automatic logic [7:0] pid_byte(input tx_packet_t code);
    case (code)
      TX_DATA0: pid_byte = PID_DATA0;
      TX_DATA1: pid_byte = PID_DATA1;
      TX_ACK:   pid_byte = PID_ACK;
      TX_NAK:   pid_byte = PID_NAK;
      TX_STALL: pid_byte = PID_STALL;
      default:  pid_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/usb_tx_packet_builder_if.sv
// Byte stream to the serializer plus the buffer TX read port, as seen by the packet builder.
interface usb_tx_packet_builder_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;
  logic       get_tx_data;
  logic [7:0] TX_packet_data;

  modport master (
    output byte_out, byte_valid, byte_last, get_tx_data,
    input  byte_ready, TX_packet_data
  );

  modport slave (
    input  byte_out, byte_valid, byte_last, get_tx_data,
    output byte_ready, TX_packet_data
  );
endinterface

// File: rtl/usb_crc16_byte.sv
// Combinational USB CRC16 update by one byte, reflected polynomial, LSB first.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC16_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/usb_tx_packet_builder.sv
// USB TX packet assembler: SYNC, PID, optional payload pulled from the buffer, CRC16.
// state     | meaning
// IDLE      | waiting for a request
// SYNC      | presenting SYNC byte
// PID       | presenting PID byte (last byte for handshakes)
// DATA_REQ  | one-cycle buffer read strobe
// DATA_WAIT | capturing buffer data, updating CRC
// DATA_SEND | presenting payload byte
// CRC_LO    | presenting inverted CRC low byte
// CRC_HI    | presenting inverted CRC high byte (last)
module usb_tx_packet_builder
  import usb_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 64,
  parameter logic [7:0] SYNC_BYTE   = usb_pkg::SYNC_BYTE
)(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     tx_packet,
  input  logic [6:0]                     buff_occ,
  usb_tx_packet_builder_if.master        bus,
  output logic                           tx_busy,
  output logic                           tx_done,
  output logic                           tx_error
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  tx_state_t   state;
  logic [7:0]  pid_q;
  logic        is_data_q;
  logic [6:0]  rem_q;
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic        xfer;
  logic        req_data;
  logic        req_hs;
  logic        req_bad;

  assign xfer = bus.byte_valid & bus.byte_ready;

  always_comb begin
    req_data = (tx_packet == TX_DATA0) || (tx_packet == TX_DATA1);
    req_hs   = (tx_packet == TX_ACK) || (tx_packet == TX_NAK) || (tx_packet == TX_STALL);
    req_bad  = (tx_packet > 3'd5) || (req_data && ({1'b0, buff_occ} > MAX_LEN));
  end

  usb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (bus.TX_packet_data),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      pid_q           <= 8'h00;
      is_data_q       <= 1'b0;
      rem_q           <= 7'd0;
      crc_q           <= CRC16_INIT;
      bus.byte_out    <= 8'h00;
      bus.byte_valid  <= 1'b0;
      bus.byte_last   <= 1'b0;
      bus.get_tx_data <= 1'b0;
      tx_busy         <= 1'b0;
      tx_done         <= 1'b0;
      tx_error        <= 1'b0;
    end else begin
      tx_done         <= 1'b0;
      tx_error        <= 1'b0;
      bus.get_tx_data <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_bad) begin
            tx_error <= 1'b1;
          end else if (req_data || req_hs) begin
            state          <= ST_SYNC;
            pid_q          <= pid_byte(tx_packet_t'(tx_packet));
            is_data_q      <= req_data;
            rem_q          <= req_data ? buff_occ : 7'd0;
            bus.byte_out   <= SYNC_BYTE;
            bus.byte_valid <= 1'b1;
            bus.byte_last  <= 1'b0;
            tx_busy        <= 1'b1;
          end
        end
        ST_SYNC: if (xfer) begin
          state         <= ST_PID;
          bus.byte_out  <= pid_q;
          bus.byte_last <= !is_data_q;
        end
        ST_PID: if (xfer) begin
          if (!is_data_q) begin
            state          <= ST_IDLE;
            bus.byte_valid <= 1'b0;
            bus.byte_last  <= 1'b0;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b1;
          end else if (rem_q != 7'd0) begin
            state           <= ST_DATA_REQ;
            bus.byte_valid  <= 1'b0;
            bus.get_tx_data <= 1'b1;
          end else begin
            state        <= ST_CRC_LO;
            bus.byte_out <= ~crc_q[7:0];
          end
        end
        ST_DATA_REQ: state <= ST_DATA_WAIT;
        ST_DATA_WAIT: begin
          state          <= ST_DATA_SEND;
          bus.byte_out   <= bus.TX_packet_data;
          bus.byte_valid <= 1'b1;
          crc_q          <= crc_next;
          rem_q          <= rem_q - 7'd1;
        end
        ST_DATA_SEND: if (xfer) begin
          if (rem_q != 7'd0) begin
            state           <= ST_DATA_REQ;
            bus.byte_valid  <= 1'b0;
            bus.get_tx_data <= 1'b1;
          end else begin
            state        <= ST_CRC_LO;
            bus.byte_out <= ~crc_q[7:0];
          end
        end
        ST_CRC_LO: if (xfer) begin
          state         <= ST_CRC_HI;
          bus.byte_out  <= ~crc_q[15:8];
          bus.byte_last <= 1'b1;
        end
        ST_CRC_HI: if (xfer) begin
          state          <= ST_IDLE;
          bus.byte_valid <= 1'b0;
          bus.byte_last  <= 1'b0;
          crc_q          <= CRC16_INIT;
          tx_busy        <= 1'b0;
          tx_done        <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_tx_packet_builder.md
Name: usb_tx_packet_builder

Overview:
- Byte-level USB TX packet assembler that sits directly downstream of the data buffer.
- On a transmit request it emits SYNC, then PID. For data packets it follows with the payload bytes pulled from the buffer via get_tx_data/TX_packet_data, then CRC16.
- Bytes are handed to the bit-level serializer (bit stuffing, NRZI, EOP) over a valid/ready handshake.
- It is the only consumer of the buffer's TX read port.

Parameters:
- MAX_PAYLOAD, 64, maximum data-packet payload bytes accepted from the buffer.
- SYNC_BYTE, 8'h80, SYNC pattern byte (LSB-first on the wire).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_packet  in  3  request code; held for one cycle: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, others reserved
- buff_occ  in  7  buffer occupancy
- TX_packet_data  in  8  buffer read data; valid the cycle after get_tx_data
- get_tx_data  out  1  single-cycle buffer read strobe
- byte_out  out  8  byte to serializer
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  serializer accepts byte_out this cycle
- byte_last  out  1  qualifies the final byte of a packet; serializer appends EOP after it
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle pulse after the last byte is accepted
- tx_error  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0: byte_out=8'h00, CRC register=16'hFFFF, byte count=0.
  - Reset mid-packet abandons the packet. No get_tx_data is issued after reset asserts.
- IDLE:
  - tx_packet in 1..5 → latch the PID and go to SYNC; tx_busy=1 from the next cycle.
  - For DATA0/DATA1, latch len=buff_occ in the same cycle.
  - If len > MAX_PAYLOAD, pulse tx_error, stay in IDLE and issue no read.
  - Reserved codes pulse tx_error. tx_packet != NONE while busy is ignored (no error).
- PID byte encodings, lower nibble = PID, upper nibble = ~PID:
  - DATA0 8'hC3, DATA1 8'h4B, ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
- Handshake rules:
  - A byte transfers when byte_valid && byte_ready.
  - While byte_valid=1 and byte_ready=0, byte_out, byte_valid and byte_last are held stable.
  - byte_valid never drops without a transfer, except on reset.
- States and transitions:
  - SYNC: byte_out=SYNC_BYTE. On transfer, go to PID.
  - PID: byte_out=PID byte. byte_last=1 for handshake PIDs.
    - Handshake PID, on transfer: go to IDLE and pulse tx_done.
    - Data PID, on transfer: go to DATA_REQ if len>0, otherwise CRC_LO.
  - DATA_REQ: get_tx_data=1 for exactly one cycle, then go to DATA_WAIT. byte_valid=0.
  - DATA_WAIT: capture TX_packet_data into byte_out, update the CRC with it, decrement the remaining count, go to DATA_SEND.
  - DATA_SEND: byte_valid=1. On transfer, go to DATA_REQ if remaining>0, otherwise CRC_LO.
  - CRC_LO: byte_out = ~crc[7:0]. On transfer, go to CRC_HI.
  - CRC_HI: byte_out = ~crc[15:8], byte_last=1. On transfer, go to IDLE, pulse tx_done, reset CRC to 16'hFFFF.
- CRC16:
  - USB CRC16, reflected polynomial 16'hA001, initial value 16'hFFFF.
  - Processed byte-wise, LSB first, over payload bytes only (not SYNC or PID).
  - Zero-length payload yields CRC bytes 8'h00, 8'h00.
- Buffer reads:
  - Exactly len get_tx_data pulses per data packet, at most one outstanding.
  - Never read when len=0.
- tx_busy is 1 from the cycle after the request through the cycle of the final transfer.
- tx_done and tx_error are never asserted in the same cycle.

Decomposition:
- Shared package usb_pkg holds:
  - tx_packet_t enum with codes 0..5.
  - PID byte constants.
  - SYNC_BYTE.
  - CRC16_POLY_REFL and CRC16_INIT.
- One sub-module, usb_crc16_byte: combinational next-CRC from (crc_in[15:0], data[7:0]).
- State register, counters and handshake stay in the top module.

Test Plan:
- Reset mid-packet:
  - Stimulus: assert rst during DATA_SEND.
  - Response: all outputs 0 immediately; no further get_tx_data; next DATA0 request starts cleanly with SYNC.
- ACK:
  - Stimulus: tx_packet=ACK, byte_ready=1.
  - Response: bytes 80, D2 with byte_last on D2; tx_done 1 cycle after; no get_tx_data.
- DATA0, zero length:
  - Stimulus: tx_packet=DATA0, buff_occ=0.
  - Response: bytes 80, C3, 00, 00; byte_last on the final 00; no get_tx_data.
- DATA1, 4-byte payload:
  - Stimulus: buffer preloaded with 81, 08, E0, FF; request DATA1.
  - Response: 80, 4B, 81, 08, E0, FF, then 2 CRC bytes matching the bench reference model.
  - Exactly 4 get_tx_data pulses; buff_occ reaches 0.
- Backpressure:
  - Stimulus: 64-byte payload of 90 with byte_ready toggling 1-in-3.
  - Response: outputs held stable during stalls; 64 reads; 68 bytes total; byte_last only on the last byte.
- Reject cases:
  - Stimulus: request with reserved code 7; separately, a second DATA0 request while busy.
  - Response: tx_error pulse and no activity for code 7; the busy request is silently ignored.
